// File: rtl/addr_burst_ctrl_if.sv
// Beat stream from the burst sequencer to the memory address bus.
// Master drives addr/addr_valid/last; slave answers with addr_ready.
// A beat moves on any rising edge where addr_valid and addr_ready are both high.
interface addr_burst_ctrl_if #(
    parameter int AW = 16
);
    logic [AW-1:0] addr;
    logic          addr_valid;
    logic          addr_ready;
    logic          last;

    modport master (
        output addr,
        output addr_valid,
        output last,
        input  addr_ready
    );

    modport slave (
        input  addr,
        input  addr_valid,
        input  last,
        output addr_ready
    );
endinterface

// File: rtl/addr_burst_ctrl.sv
// Burst sequencer steering the load/inc/dec address unit; emits one address per accepted beat.
// Latency: first beat valid two cycles after start, then one beat per cycle; done one cycle after the last beat.
// Backpressure: addr/last/addr_valid hold while addr_ready is low; only abort or reset drops a pending beat.
module addr_burst_ctrl #(
    parameter int AW = 16,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    input  logic          dir,
    input  logic          abort,
    output logic [AW-1:0] au_d,
    output logic          au_c,
    output logic          au_s,
    input  logic [AW-1:0] au_addr,
    addr_burst_ctrl_if.master beat,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [AW-1:0] base;
        logic          dir;
    } cmd_t;

    logic [1:0]    state;
    cmd_t          cmd_q;
    logic [LW-1:0] remaining;
    logic [AW-1:0] addr_q;
    logic          beat_vld;
    logic          beat_xfer;
    logic          final_beat;

    assign beat_vld   = (state == ST_RUN);
    assign beat_xfer  = beat_vld & beat.addr_ready;
    assign final_beat = (remaining == LW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            remaining <= '0;
            addr_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q.base <= base;
                        cmd_q.dir  <= dir;
                        remaining  <= len;
                        state      <= (len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // au_c=0 here, so the unit passes base straight through
                    addr_q <= au_addr;
                    state  <= abort ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (beat_xfer) begin
                        addr_q    <= au_addr;
                        remaining <= remaining - LW'(1);
                    end
                    if (abort || (beat_xfer && final_beat)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // In RUN the unit pre-computes the next address from the current one,
    // so it is ready to register on the accepting edge.
    always_comb begin
        au_d = '0;
        au_c = 1'b0;
        au_s = 1'b0;
        case (state)
            ST_LOAD: au_d = cmd_q.base;
            ST_RUN: begin
                au_d = addr_q;
                au_c = 1'b1;
                au_s = cmd_q.dir;
            end
            default: ;
        endcase
    end

    assign beat.addr       = addr_q;
    assign beat.addr_valid = beat_vld;
    assign beat.last       = beat_vld & final_beat;
    assign busy            = (state == ST_LOAD) || (state == ST_RUN);
    assign done            = (state == ST_DONE);

endmodule

// File: tb/tb_addr_burst_ctrl.sv
// Bench for addr_burst_ctrl: queue-based burst model checked every cycle, plus directed literal scenarios.
module tb_addr_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base;
    logic [7:0]  len;
    logic        dir;
    logic        abort;
    logic [15:0] au_d;
    logic        au_c;
    logic        au_s;
    logic [15:0] au_addr;
    logic        busy;
    logic        done;

    addr_burst_ctrl_if #(.AW(16)) ab ();

    addr_burst_ctrl #(.AW(16), .LW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .len     (len),
        .dir     (dir),
        .abort   (abort),
        .au_d    (au_d),
        .au_c    (au_c),
        .au_s    (au_s),
        .au_addr (au_addr),
        .beat    (ab),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // external address unit: pass, +1 or -1, modulo 2^16
    assign au_addr = au_c ? (au_s ? au_d - 16'd1 : au_d + 16'd1) : au_d;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the burst is the list of addresses still to be delivered.
    logic [15:0] mq[$];
    bit          m_load = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_base = '0;
    bit          m_dir  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_load = 1'b0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_load) begin
            m_load = 1'b0;
            if (abort) begin
                mq.delete();
                m_done = 1'b1;
            end
        end else if (mq.size() > 0) begin
            if (ab.addr_ready) void'(mq.pop_front());
            if (abort) begin
                mq.delete();
                m_done = 1'b1;
            end else if (mq.size() == 0) begin
                m_done = 1'b1;
            end
        end else if (start) begin
            m_base = base;
            m_dir  = dir;
            if (len == 8'd0) begin
                m_done = 1'b1;
            end else begin
                logic [15:0] a;
                a = base;
                m_load = 1'b1;
                for (int k = 0; k < int'(len); k++) begin
                    mq.push_back(a);
                    a = dir ? a - 16'd1 : a + 16'd1;
                end
            end
        end
    end

    logic [15:0] log_a[$];
    bit          log_l[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          vld_cnt  = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit          e_vld;
            logic [15:0] e_d;
            e_vld = !m_load && (mq.size() > 0);
            e_d   = m_load ? m_base : (e_vld ? mq[0] : 16'h0000);
            chk("addr_valid", ab.addr_valid, e_vld);
            chk("busy", busy, m_load || (mq.size() > 0));
            chk("done", done, m_done);
            chk("last", ab.last, e_vld && (mq.size() == 1));
            chk("au_c", au_c, e_vld);
            chk("au_s", au_s, e_vld && m_dir);
            chk("au_d", au_d, e_d);
            if (e_vld) chk("addr", ab.addr, mq[0]);
            if (ab.addr_valid && ab.addr_ready) begin
                log_a.push_back(ab.addr);
                log_l.push_back(ab.last);
            end
            if (done)          done_cnt++;
            if (busy)          busy_cnt++;
            if (ab.addr_valid) vld_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [15:0] b, input logic [7:0] l, input logic d);
        start = 1'b1;
        base  = b;
        len   = l;
        dir   = d;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk(nm, seen, 1'b1);
        tick();
    endtask

    task automatic check_log(input string nm, input int n, input bit last_at_end,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] ex[5];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
        chk({nm, "_count"}, log_a.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({nm, "_addr"}, (i < log_a.size()) ? {16'h0, log_a[i]} : 32'hdead_beef, ex[i]);
            chk({nm, "_last"}, (i < log_l.size()) ? {31'h0, log_l[i]} : 32'hdead_beef,
                last_at_end && (i == n - 1));
        end
        log_a.delete();
        log_l.delete();
    endtask

    initial begin
        int d0, b0, v0;
        rst_n         = 1'b0;
        start         = 1'b0;
        base          = '0;
        len           = '0;
        dir           = 1'b0;
        abort         = 1'b0;
        ab.addr_ready = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_addr", ab.addr, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of RUN
        ab.addr_ready = 1'b1;
        start_burst(16'h0100, 8'd8, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_addr", ab.addr, 16'h0000);
        chk("midrst_valid", ab.addr_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_last", ab.last, 1'b0);
        chk("midrst_au", {au_d, au_c, au_s}, 18'h0);
        log_a.delete();
        log_l.delete();
        tick();

        // ascending burst
        d0 = done_cnt;
        start_burst(16'h1000, 8'd4, 1'b0);
        chk("model_len", mq.size(), 4);
        chk("model_q3", mq[3], 16'h1003);
        chk("load_busy", busy, 1'b1);
        tick();
        chk("first_beat", ab.addr, 16'h1000);
        wait_done("asc_done", 10);
        check_log("asc", 4, 1'b1, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h0);
        chk("asc_done_pulses", done_cnt - d0, 1);

        // wrap both directions
        start_burst(16'hFFFE, 8'd3, 1'b0);
        chk("model_wrap", mq[2], 16'h0000);
        wait_done("wrapup_done", 10);
        check_log("wrapup", 3, 1'b1, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0, 16'h0);
        start_burst(16'h0001, 8'd3, 1'b1);
        wait_done("wrapdn_done", 10);
        check_log("wrapdn", 3, 1'b1, 16'h0001, 16'h0000, 16'hFFFF, 16'h0, 16'h0);

        // backpressure
        begin
            bit pat[8];
            pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            ab.addr_ready = 1'b0;
            start_burst(16'h0200, 8'd5, 1'b0);
            tick();
            for (int i = 0; i < 8; i++) begin
                ab.addr_ready = pat[i];
                tick();
            end
            ab.addr_ready = 1'b1;
            chk("bp_done", done, 1'b1);
            tick();
            check_log("bp", 5, 1'b1, 16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204);
        end

        // zero-length command
        d0 = done_cnt; b0 = busy_cnt; v0 = vld_cnt;
        start_burst(16'h0500, 8'd0, 1'b0);
        chk("len0_done", done, 1'b1);
        tick();
        chk("len0_done_off", done, 1'b0);
        tick();
        chk("len0_pulses", done_cnt - d0, 1);
        chk("len0_busy", busy_cnt - b0, 0);
        chk("len0_valid", vld_cnt - v0, 0);

        // abort after the second transfer
        start_burst(16'h0300, 8'd5, 1'b0);
        tick();
        tick();
        tick();
        ab.addr_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1'b1);
        chk("abort_valid", ab.addr_valid, 1'b0);
        tick();
        check_log("abort", 2, 1'b0, 16'h0300, 16'h0301, 16'h0, 16'h0, 16'h0);

        // start during RUN is ignored
        ab.addr_ready = 1'b1;
        start_burst(16'h0400, 8'd5, 1'b1);
        tick();
        start_burst(16'h0777, 8'd2, 1'b0);
        wait_done("ign_done", 12);
        check_log("ignstart", 5, 1'b1, 16'h0400, 16'h03FF, 16'h03FE, 16'h03FD, 16'h03FC);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ab.addr_ready = ($urandom_range(0, 3) != 0);
            abort         = ($urandom_range(0, 40) == 0);
            start         = ($urandom_range(0, 4) == 0);
            base          = 16'($urandom);
            len           = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            dir           = 1'($urandom_range(0, 1));
            rst_n         = ($urandom_range(0, 400) != 0);
            tick();
        end
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/addr_burst_ctrl.md
# addr_burst_ctrl

Sequencer for the 16-bit address unit (load / increment / decrement datapath with inputs d, c, s and output address). It accepts a burst command (base, length, direction) and drives the unit's control inputs cycle by cycle: one load, then one step per accepted beat. It presents the resulting address stream on a valid/ready interface with last, busy and done indications. It sits between a DMA-style command source and the memory address bus.

## Interface
- AW, 16, address width; must equal the address unit width.
- LW, 8, burst length field width; maximum burst is 2^LW-1 beats.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  command strobe; sampled only in IDLE.
- base  input  AW  first address of the burst.
- len  input  LW  number of beats; 0 means no beats.
- dir  input  1  0 = ascending, 1 = descending.
- abort  input  1  terminate the current burst.
- au_d  output  AW  to address unit d.
- au_c  output  1  to address unit c (0 = pass, 1 = step).
- au_s  output  1  to address unit s (0 = +1, 1 = -1 when c=1).
- au_addr  input  AW  from address unit address (combinational on au_d/c/s).
- addr  output  AW  current beat address (registered).
- addr_valid  output  1  beat available.
- addr_ready  input  1  consumer accepts beat.
- last  output  1  final beat of the burst.
- busy  output  1  burst in LOAD or RUN.
- done  output  1  one-cycle completion pulse.

## Operation
- Clock ports: clk. Reset: rst_n, synchronous and active-low.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On start=1, latch base, len and dir.
  - If len=0, go to DONE. Otherwise go to LOAD and set remaining=len.
- LOAD:
  - Drive au_d=base_q, au_c=0, au_s=0.
  - Register addr<=au_addr, which equals base.
  - Go to RUN.
- RUN:
  - Drive au_d=addr, au_c=1, au_s=dir_q.
  - A beat transfers on an edge where addr_valid and addr_ready are both 1.
  - On each transfer: addr<=au_addr, remaining<=remaining-1.
  - The transfer with remaining=1 moves the block to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- abort in LOAD or RUN: go to DONE on that edge; no further beats are issued. A beat handshaking on the same edge counts as transferred. abort is ignored in IDLE and DONE.
- start outside IDLE is ignored; no queuing.
- Output decode:
  - addr_valid=1 only in RUN.
  - busy=1 in LOAD and RUN.
  - last = addr_valid & (remaining==1).
- Wrap-around is modulo 2^AW, with no error or flag: 0xFFFF ascending steps to 0x0000; 0x0000 descending steps to 0xFFFF.
- In IDLE and DONE: au_d=0, au_c=0, au_s=0.
- Reset (rst_n=0 at an edge), from any state including mid-burst: state=IDLE; addr, addr_valid, last, busy, done, au_d, au_c, au_s all 0; remaining=0. Reset overrides start and abort.

## Timing
- start sampled at edge E0 → LOAD and busy=1 after E0. After E1: RUN, addr_valid=1, addr=base. First beat is available 2 cycles after start.
- With addr_ready held at 1: one beat per cycle; a burst of N beats occupies RUN for N cycles, and done pulses in the cycle after the last transfer.
- len=0: start at E0 → done=1 after E0 for one cycle. busy and addr_valid stay 0.
- Backpressure: while addr_ready=0, addr, last and addr_valid hold stable. addr_valid never deasserts before the transfer, except on abort or reset.
- A new start is accepted in the first IDLE cycle after done. Minimum start-to-start spacing is N+3 cycles.
- au_addr is consumed combinationally in the same cycle it is driven; no added latency.

## Test plan
- Reset: assert rst_n=0 for 1 edge mid-RUN → next cycle all outputs 0, state IDLE; a later start works normally.
- Ascending burst: base=0x1000, len=4, dir=0, ready=1 → addr 0x1000, 0x1001, 0x1002, 0x1003 on 4 consecutive cycles. last only on 0x1003; done one cycle later.
- Wrap, both directions:
  - base=0xFFFE, len=3, dir=0 → 0xFFFE, 0xFFFF, 0x0000.
  - base=0x0001, len=3, dir=1 → 0x0001, 0x0000, 0xFFFF.
- Backpressure: base=0x0200, len=5, ready pattern 1,0,0,1,1,0,1,1 → exactly 5 transfers 0x0200..0x0204; addr stable while ready=0; au_c=1 throughout RUN.
- len=0 with start → done pulse after the start edge; addr_valid never 1; busy never 1.
- Abort and ignored start: len=5, abort asserted after the 2nd transfer → no further beats, done next cycle. A start pulsed during RUN is ignored; the beat count is unchanged.
